// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer with return stack, cycle counter and run/done handshake.
module fetch_sequencer #(
  parameter int AW = 10,
  parameter int SD = 4,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_halt,
  input  logic          i_branch_abs_en,
  input  logic          i_branch_rel_en,
  input  logic          i_cond,
  input  logic [AW-1:0] i_target,
  input  logic          i_call,
  input  logic          i_ret,
  input  logic          i_stall,
  output logic [AW-1:0] o_prog_ctr,
  output logic          o_running,
  output logic          o_ack,
  output logic [CW-1:0] o_cycle_count,
  output logic          o_stack_err
);
  localparam int SPW = $clog2(SD + 1);
  localparam int IW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(SD);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t         r_state;
  logic [AW-1:0]  r_pc;
  logic [SPW-1:0] r_sp;
  logic [CW-1:0]  r_cnt;
  logic           r_err;
  logic           r_running;
  logic           r_ack;
  logic [AW-1:0]  r_stack [0:(1<<IW)-1];

  logic [SPW-1:0] w_sp_dec;
  logic [AW-1:0]  w_pc_inc;
  logic [AW-1:0]  w_pc_next;
  logic           w_act;
  logic           w_pop;
  logic           w_under;
  logic           w_call;
  logic           w_push;
  logic           w_over;

  // w_act: a RUN cycle in which the program actually advances
  assign w_act    = (r_state == RUN) && !i_start && !i_stall && !i_halt;
  assign w_sp_dec = r_sp - 1'b1;
  assign w_pc_inc = r_pc + 1'b1;
  assign w_pop    = w_act && i_ret && (|r_sp);
  assign w_under  = w_act && i_ret && !(|r_sp);
  assign w_call   = w_act && !i_ret && i_branch_abs_en && i_call;
  assign w_push   = w_call && (r_sp != SP_FULL);
  assign w_over   = w_call && (r_sp == SP_FULL);

  always_comb begin
    w_pc_next = !w_act ? r_pc :
                i_ret ? ((|r_sp) ? r_stack[w_sp_dec[IW-1:0]] : w_pc_inc) :
                i_branch_abs_en ? i_target :
                (i_branch_rel_en && i_cond) ? r_pc + i_target :
                w_pc_inc;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_stack[r_sp[IW-1:0]] <= w_pc_inc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_sp      <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_running <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) r_state <= ARMED;
        ARMED: begin
          r_pc  <= '0;
          r_sp  <= '0;
          r_cnt <= '0;
          r_err <= 1'b0;
          if (!i_start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
          r_pc  <= w_pc_next;
          r_sp  <= w_push ? r_sp + 1'b1 : w_pop ? w_sp_dec : r_sp;
          if (w_under || w_over) r_err <= 1'b1;
          if (i_start) begin
            r_state   <= ARMED;
            r_running <= 1'b0;
          end else if (!i_stall && i_halt) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_ack     <= 1'b1;
          end
        end
        DONE: if (i_start) begin
          r_state <= ARMED;
          r_ack   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_prog_ctr    = r_pc;
  assign o_running     = r_running;
  assign o_ack         = r_ack;
  assign o_cycle_count = r_cnt;
  assign o_stack_err   = r_err;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a behavioural model.
module tb_fetch_sequencer;
  localparam int AW = 5;
  localparam int SD = 2;
  localparam int CW = 6;
  localparam int N = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

  logic clk = 0, rst_n = 0, start = 0, halt = 0, abs_en = 0, rel_en = 0;
  logic cond = 0, call = 0, ret = 0, stall = 0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] pc;
  logic running, ack, serr;
  logic [CW-1:0] cnt;

  int n_checks = 0, n_errors = 0;
  bit chk_en = 0;
  int m_mode = M_IDLE, m_pc = 0, m_cnt = 0;
  bit m_err = 0;
  int m_stk[$];

  always #5 clk = ~clk;

  fetch_sequencer #(.AW(AW), .SD(SD), .CW(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_halt(halt),
    .i_branch_abs_en(abs_en), .i_branch_rel_en(rel_en), .i_cond(cond),
    .i_target(target), .i_call(call), .i_ret(ret), .i_stall(stall),
    .o_prog_ctr(pc), .o_running(running), .o_ack(ack),
    .o_cycle_count(cnt), .o_stack_err(serr)
  );

  function automatic int wrap(int v);
    return ((v % N) + N) % N;
  endfunction

  function automatic int sext(int t);
    return (t >= N / 2) ? t - N : t;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE;
      m_pc   <= 0;
      m_cnt  <= 0;
      m_err  <= 0;
      m_stk.delete();
    end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
      if (start) m_mode <= M_ARMED;
    end else if (m_mode == M_ARMED) begin
      m_pc  <= 0;
      m_cnt <= 0;
      m_err <= 0;
      m_stk.delete();
      if (!start) m_mode <= M_RUN;
    end else begin
      m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (start) m_mode <= M_ARMED;
      else if (!stall) begin
        if (halt) m_mode <= M_DONE;
        else if (ret) begin
          if (m_stk.size() > 0) m_pc <= m_stk.pop_back();
          else begin
            m_pc  <= wrap(m_pc + 1);
            m_err <= 1;
          end
        end else if (abs_en) begin
          if (call) begin
            if (m_stk.size() < SD) m_stk.push_back(wrap(m_pc + 1));
            else m_err <= 1;
          end
          m_pc <= int'(target);
        end else if (rel_en && cond) m_pc <= wrap(m_pc + sext(int'(target)));
        else m_pc <= wrap(m_pc + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", pc, m_pc);
      check("model_running", running, int'(m_mode == M_RUN));
      check("model_ack", ack, int'(m_mode == M_DONE));
      check("model_cnt", cnt, m_cnt);
      check("model_stack_err", serr, m_err);
    end
  end

  initial begin
    repeat (2) cyc();
    chk_en = 1;
    check("rst_pc", pc, 0);
    check("rst_running", running, 0);
    check("rst_ack", ack, 0);
    check("rst_cnt", cnt, 0);
    rst_n = 1;
    start = 1;
    repeat (3) cyc();
    check("armed_running", running, 0);
    start = 0;
    cyc();
    check("run_rise", running, 1);
    check("run_pc0", pc, 0);
    cyc();
    check("run_pc1", pc, 1);
    cyc();
    check("run_pc2", pc, 2);
    check("run_cnt2", cnt, 2);
    repeat (30) cyc();
    check("wrap_pc", pc, 0);
    check("wrap_cnt", cnt, 32);
    repeat (40) cyc();
    check("sat_cnt", cnt, 63);
    check("sat_pc", pc, 8);
    start = 1;
    cyc();
    check("restart_running", running, 0);
    cyc();
    check("restart_cnt_clr", cnt, 0);
    start = 0;
    cyc();
    repeat (5) cyc();
    check("at_pc5", pc, 5);
    rel_en = 1; cond = 1; target = AW'(-3);
    cyc();
    check("rel_taken", pc, 2);
    rel_en = 0; abs_en = 1; target = 5;
    cyc();
    check("abs_jump", pc, 5);
    abs_en = 0; rel_en = 1; cond = 0;
    cyc();
    check("rel_not_taken", pc, 6);
    rel_en = 0; halt = 1; abs_en = 1; target = 17;
    cyc();
    check("halt_ack", ack, 1);
    check("halt_running", running, 0);
    check("halt_pc", pc, 6);
    check("halt_cnt", cnt, 9);
    halt = 0; abs_en = 0;
    repeat (2) cyc();
    check("done_pc_hold", pc, 6);
    check("done_cnt_hold", cnt, 9);
    start = 1;
    cyc();
    check("done_ack_fall", ack, 0);
    cyc();
    start = 0;
    cyc();
    check("rerun_pc", pc, 0);
    check("rerun_cnt", cnt, 0);
    cyc();
    abs_en = 1; call = 1; target = 10;
    cyc();
    target = 20;
    cyc();
    target = 30;
    cyc();
    check("call3_pc", pc, 30);
    check("overflow_err", serr, 1);
    abs_en = 0; call = 0; ret = 1;
    cyc();
    check("ret1_pc", pc, 11);
    cyc();
    check("ret2_pc", pc, 2);
    cyc();
    check("underflow_pc", pc, 3);
    check("underflow_err", serr, 1);
    ret = 0;
    repeat (4) cyc();
    check("pre_stall_pc", pc, 7);
    stall = 1;
    repeat (4) cyc();
    check("stall_pc", pc, 7);
    check("stall_cnt", cnt, 15);
    #3 rst_n = 0;
    #1;
    check("async_pc", pc, 0);
    check("async_running", running, 0);
    check("async_cnt", cnt, 0);
    check("async_err", serr, 0);
    check("async_ack", ack, 0);
    stall = 0;
    cyc();
    rst_n = 1;
    repeat (2) cyc();
    check("post_rst_idle", running, 0);
    for (int i = 0; i < 3000; i++) begin
      start  = (m_mode == M_RUN) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1);
      halt   = ($urandom_range(0, 29) == 0);
      stall  = ($urandom_range(0, 5) == 0);
      ret    = ($urandom_range(0, 5) == 0);
      abs_en = ($urandom_range(0, 4) == 0);
      call   = ($urandom_range(0, 1) == 1);
      rel_en = ($urandom_range(0, 3) == 0);
      cond   = ($urandom_range(0, 1) == 1);
      target = AW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 0;
        #2 rst_n = 1;
      end
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
